// File: rtl/otter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_ctrl_pkg
// Brief    : Opcodes, ALU codes, mux-select encodings and the control bundle
//            shared by the OTTER decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package otter_ctrl_pkg;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;
    localparam logic [3:0] c_ALU_COPY = 4'b1001;

    typedef enum logic [1:0] {
        SRCA_RS1     = 2'd0,
        SRCA_UIMM    = 2'd1,
        SRCA_NOT_RS1 = 2'd2
    } srca_t;

    typedef enum logic [2:0] {
        SRCB_RS2  = 3'd0,
        SRCB_IIMM = 3'd1,
        SRCB_SIMM = 3'd2,
        SRCB_PC   = 3'd3,
        SRCB_CSR  = 3'd4
    } srcb_t;

    typedef enum logic [1:0] {
        WSEL_PC4 = 2'd0,
        WSEL_CSR = 2'd1,
        WSEL_MEM = 2'd2,
        WSEL_ALU = 2'd3
    } wsel_t;

    typedef enum logic [2:0] {
        PCS_PC4    = 3'd0,
        PCS_JALR   = 3'd1,
        PCS_BRANCH = 3'd2,
        PCS_JAL    = 3'd3,
        PCS_MRET   = 3'd5
    } pcsrc_t;

    typedef struct packed {
        logic [3:0] alu_fun;
        srca_t      alu_srcA;
        srcb_t      alu_srcB;
        wsel_t      rf_wr_sel;
        pcsrc_t     pcSource;
        logic       regWrite;
        logic       memWrite;
        logic       memRead2;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c.alu_fun   = c_ALU_ADD;
        c.alu_srcA  = SRCA_RS1;
        c.alu_srcB  = SRCB_RS2;
        c.rf_wr_sel = WSEL_ALU;
        c.pcSource  = PCS_PC4;
        c.regWrite  = 1'b0;
        c.memWrite  = 1'b0;
        c.memRead2  = 1'b0;
        c.illegal   = 1'b0;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : otter_ctrl_decode
// Brief    : Combinational RV32I instruction -> control bundle decoder.
//            SYSTEM/CSR decode enabled by macro OTTER_DECODE_CSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module otter_ctrl_decode
    import otter_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl
);

    ctrl_t      w_ctrl;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused;

    assign w_opcode = ir[6:0];
    assign w_funct3 = ir[14:12];
    assign w_unused = &{1'b0, ir[31], ir[29:15]};

    always_comb begin
        w_ctrl = ctrl_default();
        case (w_opcode)
            c_OPC_OP: begin
                w_ctrl.alu_fun  = {ir[30], w_funct3};
                w_ctrl.regWrite = 1'b1;
            end
            c_OPC_OP_IMM: begin
                // only the shift-right immediates carry a meaningful bit 30
                w_ctrl.alu_fun  = (w_funct3 == 3'b101) ? {ir[30], w_funct3} : {1'b0, w_funct3};
                w_ctrl.alu_srcB = SRCB_IIMM;
                w_ctrl.regWrite = 1'b1;
            end
            c_OPC_LOAD: begin
                w_ctrl.alu_srcB  = SRCB_IIMM;
                w_ctrl.rf_wr_sel = WSEL_MEM;
                w_ctrl.memRead2  = 1'b1;
                w_ctrl.regWrite  = 1'b1;
            end
            c_OPC_JALR: begin
                w_ctrl.alu_srcB  = SRCB_IIMM;
                w_ctrl.rf_wr_sel = WSEL_PC4;
                w_ctrl.pcSource  = PCS_JALR;
                w_ctrl.regWrite  = 1'b1;
            end
            c_OPC_STORE: begin
                w_ctrl.alu_srcB = SRCB_SIMM;
                w_ctrl.memWrite = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_ctrl.pcSource = PCS_BRANCH;
            end
            c_OPC_LUI: begin
                w_ctrl.alu_fun  = c_ALU_COPY;
                w_ctrl.alu_srcA = SRCA_UIMM;
                w_ctrl.regWrite = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_ctrl.alu_srcA = SRCA_UIMM;
                w_ctrl.alu_srcB = SRCB_PC;
                w_ctrl.regWrite = 1'b1;
            end
            c_OPC_JAL: begin
                w_ctrl.rf_wr_sel = WSEL_PC4;
                w_ctrl.pcSource  = PCS_JAL;
                w_ctrl.regWrite  = 1'b1;
            end
`ifdef OTTER_DECODE_CSR_EN
            c_OPC_SYSTEM: begin
                w_ctrl.alu_srcB  = SRCB_CSR;
                w_ctrl.rf_wr_sel = WSEL_CSR;
                w_ctrl.regWrite  = 1'b1;
                case (w_funct3)
                    3'b001: w_ctrl.alu_fun = c_ALU_COPY;
                    3'b010: w_ctrl.alu_fun = c_ALU_OR;
                    3'b011: begin
                        w_ctrl.alu_srcA = SRCA_NOT_RS1;
                        w_ctrl.alu_fun  = c_ALU_AND;
                    end
                    3'b000: begin
                        w_ctrl.pcSource = PCS_MRET;
                        w_ctrl.regWrite = 1'b0;
                    end
                    default: begin
                        w_ctrl         = ctrl_default();
                        w_ctrl.illegal = 1'b1;
                    end
                endcase
            end
`endif
            default: begin
                w_ctrl.illegal = 1'b1;
            end
        endcase
        // x0 is hardwired to zero, so never request a write to it
        if (ir[11:7] == 5'd0) begin
            w_ctrl.regWrite = 1'b0;
        end
    end

    assign ctrl = w_ctrl;

endmodule
`default_nettype wire

// File: rtl/otter_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : otter_decode_stage
// Brief    : Registered OTTER decode stage: decodes fetched instructions and
//            queues {ctrl, pc, ir} in a DEPTH-entry FIFO with valid/ready.
//            Optional CSR decode via macro OTTER_DECODE_CSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module otter_decode_stage
    import otter_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_ir,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_ir,
    output logic [XLEN-1:0]            out_pc,
    output logic [3:0]                 out_alu_fun,
    output logic [1:0]                 out_alu_srcA,
    output logic [2:0]                 out_alu_srcB,
    output logic [1:0]                 out_rf_wr_sel,
    output logic [2:0]                 out_pcSource,
    output logic                       out_regWrite,
    output logic                       out_memWrite,
    output logic                       out_memRead2,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    ctrl_t           w_dec;
    ctrl_t           r_ctrl [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [XLEN-1:0] r_ir   [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;
    ctrl_t           w_head;

    otter_ctrl_decode u_decode (
        .ir   (in_ir[31:0]),
        .ctrl (w_dec)
    );

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (r_count != '0);
    assign in_ready  = (r_count < CW'(DEPTH)) || out_ready;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= '0;
                r_pc[i]   <= '0;
                r_ir[i]   <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_ctrl[r_wr_ptr] <= w_dec;
                r_pc[r_wr_ptr]   <= in_pc;
                r_ir[r_wr_ptr]   <= in_ir;
                r_wr_ptr         <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign w_head        = r_ctrl[r_rd_ptr];
    assign out_ir        = r_ir[r_rd_ptr];
    assign out_pc        = r_pc[r_rd_ptr];
    assign out_alu_fun   = w_head.alu_fun;
    assign out_alu_srcA  = w_head.alu_srcA;
    assign out_alu_srcB  = w_head.alu_srcB;
    assign out_rf_wr_sel = w_head.rf_wr_sel;
    assign out_pcSource  = w_head.pcSource;
    assign out_regWrite  = w_head.regWrite;
    assign out_memWrite  = w_head.memWrite;
    assign out_memRead2  = w_head.memRead2;
    assign out_illegal   = w_head.illegal;
    assign count         = r_count;

endmodule
`default_nettype wire
